// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and helpers for the byte-serial memory sequencer
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 11;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    // Number of single-byte RAM cycles an access needs; 0 for the illegal size.
    function automatic logic [2:0] size_nbytes(input size_e sz);
        case (sz)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            SZ_WORD: size_nbytes = 3'd4;
            default: size_nbytes = 3'd0;
        endcase
    endfunction

    // Requests that are answered with an error instead of touching RAM.
    function automatic logic is_bad_req(input size_e sz, input logic [1:0] a_lo);
        case (sz)
            SZ_BYTE: is_bad_req = 1'b0;
            SZ_HALF: is_bad_req = a_lo[0];
            SZ_WORD: is_bad_req = (a_lo != 2'b00);
            default: is_bad_req = 1'b1;
        endcase
    endfunction

    // Capture register holds the accessed bytes right-justified, MSB first.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input size_e sz,
                                                input logic uns);
        case (sz)
            SZ_BYTE: load_extend = uns ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: load_extend = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - two-way round-robin arbiter between fetch and data requesters
module mem_rr_arb
    import mem_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  logic   if_valid_i,
    input  logic   d_valid_i,
    output grant_e gnt_o,
    output logic   if_ready_o,
    output logic   d_ready_o
);

    grant_e last_grant_q, last_grant_d;

    // Pick a winner: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        gnt_o        = GNT_IF;
        last_grant_d = last_grant_q;
        if (if_valid_i && d_valid_i) begin
            gnt_o = (last_grant_q == GNT_D) ? GNT_IF : GNT_D;
        end else if (d_valid_i) begin
            gnt_o = GNT_D;
        end
        if_ready_o = en_i && if_valid_i && (gnt_o == GNT_IF);
        d_ready_o  = en_i && d_valid_i && (gnt_o == GNT_D);
        if (if_ready_o || d_ready_o) begin
            last_grant_d = gnt_o;
        end
    end

    // Remember the last served port; after reset fetch wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// rtl/mem_seq_ctrl.sv - byte-serial RAM sequencer for fetch and load/store ports; optional counters via MEM_SEQ_STATS_EN
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
`ifdef MEM_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_if_grants,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_errs
`endif
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_d;
    grant_e            arb_gnt;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        n_q, n_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              arb_en;
    logic              d_bad;
    size_e             d_size_e;

    // Requests are only taken in IDLE, and never while reset is asserted.
    assign arb_en   = (state_q == IDLE) && !rst;
    assign d_size_e = size_e'(d_size);
    assign d_bad    = is_bad_req(d_size_e, d_addr[1:0]);

    mem_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .en_i       (arb_en),
        .if_valid_i (if_req_valid),
        .d_valid_i  (d_req_valid),
        .gnt_o      (arb_gnt),
        .if_ready_o (if_req_ready),
        .d_ready_o  (d_req_ready)
    );

    // Sequencer next-state and outputs: latch a request, walk its bytes, then respond.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        cap_d       = cap_q;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = 8'h00;
        if_rsp_valid = 1'b0;
        if_rdata    = '0;
        d_rsp_valid = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                cap_d = '0;
                if (if_req_ready) begin
                    gnt_d   = GNT_IF;
                    base_d  = if_addr & WORD_MASK;
                    n_d     = 3'd4;
                    we_d    = 1'b0;
                    size_d  = SZ_WORD;
                    uns_d   = 1'b1;
                    err_d   = 1'b0;
                    wdata_d = '0;
                    state_d = XFER;
                end else if (d_req_ready) begin
                    gnt_d  = arb_gnt;
                    base_d = d_addr;
                    n_d    = size_nbytes(d_size_e);
                    we_d   = d_we && !d_bad;
                    size_d = d_size_e;
                    uns_d  = d_unsigned;
                    err_d  = d_bad;
                    // Left-justify store data so the byte to send is always the top byte.
                    case (d_size_e)
                        SZ_BYTE: wdata_d = {d_wdata[7:0], 24'h0};
                        SZ_HALF: wdata_d = {d_wdata[15:0], 16'h0};
                        default: wdata_d = d_wdata;
                    endcase
                    state_d = d_bad ? RESP : XFER;
                end
            end
            XFER: begin
                ram_addr  = base_q + ADDR_W'(cnt_q);
                ram_we    = we_q;
                ram_wdata = wdata_q[DATA_W-1:DATA_W-8];
                wdata_d   = wdata_q << 8;
                cap_d     = {cap_q[DATA_W-9:0], ram_rdata};
                cnt_d     = cnt_q + 2'd1;
                if ({1'b0, cnt_q} == (n_q - 3'd1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (gnt_q == GNT_IF) begin
                    if_rsp_valid = 1'b1;
                    if_rdata     = cap_q;
                end else begin
                    d_rsp_valid = 1'b1;
                    d_err       = err_q;
                    d_rdata     = (err_q || we_q) ? '0 : load_extend(cap_q, size_q, uns_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IF;
            base_q  <= '0;
            n_q     <= 3'd0;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            base_q  <= base_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
        end
    end

`ifdef MEM_SEQ_STATS_EN
    logic [15:0] stat_if_q, stat_d_q, stat_err_q;
    logic        err_rsp;

    assign err_rsp        = (state_q == RESP) && (gnt_q == GNT_D) && err_q;
    assign stat_if_grants = stat_if_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_errs      = stat_err_q;

    // Saturating event counters for grants and error responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_q  <= 16'h0;
            stat_d_q   <= 16'h0;
            stat_err_q <= 16'h0;
        end else begin
            if (if_req_ready && (stat_if_q != 16'hFFFF)) begin
                stat_if_q <= stat_if_q + 16'd1;
            end
            if (d_req_ready && (stat_d_q != 16'hFFFF)) begin
                stat_d_q <= stat_d_q + 16'd1;
            end
            if (err_rsp && (stat_err_q != 16'hFFFF)) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb/tb_mem_seq_ctrl.sv - directed self-checking bench for mem_seq_ctrl
module tb_mem_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [10:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [10:0] d_addr;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:2047];
    int          checks;
    int          errors;

    mem_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_we         (d_we),
        .d_size       (d_size),
        .d_unsigned   (d_unsigned),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External byte RAM: combinational read, clocked write.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request and follow it to its response; lat counts cycles after accept.
    task automatic do_req(input bit port_d, input bit we, input logic [1:0] size, input bit uns,
                          input logic [10:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int we_cycles);
        int wait_c;
        bit got;
        lat = -1;
        rdata = 32'h0;
        err = 1'b0;
        we_cycles = 0;
        @(negedge clk);
        if (port_d) begin
            d_req_valid = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
            d_addr = addr; d_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        #1;
        wait_c = 0;
        while (!(port_d ? d_req_ready : if_req_ready) && wait_c < 20) begin
            @(negedge clk);
            #1;
            wait_c++;
        end
        checks++;
        if (wait_c >= 20) begin
            errors++;
            $display("FAIL handshake_timeout port_d=%0d addr=%h no ready in 20 cycles", port_d, addr);
            if_req_valid = 1'b0;
            d_req_valid  = 1'b0;
            return;
        end
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if_req_valid = 1'b0;
            d_req_valid  = 1'b0;
            #1;
            if (ram_we) we_cycles++;
            if (port_d ? d_rsp_valid : if_rsp_valid) begin
                got = 1'b1;
                lat = k;
                rdata = port_d ? d_rdata : if_rdata;
                err = d_err;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", {if_req_ready, d_req_ready});
        end
        checks++;
        if ({if_rsp_valid, d_rsp_valid, d_err, ram_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {if_rsp_valid, d_rsp_valid, d_err, ram_we});
        end
        checks++;
        if ({ram_addr, ram_wdata, if_rdata, d_rdata} !== 83'h0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h if_rdata=%h d_rdata=%h exp 0",
                               ram_addr, ram_wdata, if_rdata, d_rdata);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_store();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, lat, rd, er, wc);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL wstore_lat got %0d exp 5", lat); end
        checks++;
        if (wc !== 4) begin errors++; $display("FAIL wstore_we_cycles got %0d exp 4", wc); end
        checks++;
        if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wstore_ram got %h exp deadbeef", {mem[16], mem[17], mem[18], mem[19]});
        end
        checks++;
        if ({er, rd} !== 33'h0) begin errors++; $display("FAIL wstore_rsp got err=%b rdata=%h exp 0 0", er, rd); end
    endtask

    task automatic test_word_load();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 11'h010, 32'h0, lat, rd, er, wc);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL wload_lat got %0d exp 5", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wload_data got %h exp deadbeef", rd); end
        checks++;
        if (wc !== 0 || er !== 1'b0) begin errors++; $display("FAIL wload_flags got we=%0d err=%b exp 0 0", wc, er); end
    endtask

    task automatic test_byte_load();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 11'h012, 32'h0, lat, rd, er, wc);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL bload_lat got %0d exp 2", lat); end
        checks++;
        if (rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL bload_signed got %h exp ffffffbe", rd); end
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 11'h012, 32'h0, lat, rd, er, wc);
        checks++;
        if (rd !== 32'h000000BE) begin errors++; $display("FAIL bload_unsigned got %h exp 000000be", rd); end
        do_req(1'b1, 1'b1, 2'b00, 1'b0, 11'h030, 32'h1234565A, lat, rd, er, wc);
        checks++;
        if (mem[48] !== 8'h5A || wc !== 1) begin
            errors++; $display("FAIL bstore got ram=%h we=%0d exp 5a 1", mem[48], wc);
        end
    endtask

    task automatic test_half();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b1, 1'b1, 2'b01, 1'b0, 11'h7FE, 32'h00001234, lat, rd, er, wc);
        checks++;
        if ({mem[2046], mem[2047]} !== 16'h1234 || wc !== 2) begin
            errors++; $display("FAIL hstore_top got %h we=%0d exp 1234 2", {mem[2046], mem[2047]}, wc);
        end
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 11'h7FE, 32'h0, lat, rd, er, wc);
        checks++;
        if (rd !== 32'h00001234 || lat !== 3) begin
            errors++; $display("FAIL hload_top got %h lat=%0d exp 00001234 3", rd, lat);
        end
        do_req(1'b1, 1'b1, 2'b01, 1'b0, 11'h020, 32'h55558ABC, lat, rd, er, wc);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 11'h020, 32'h0, lat, rd, er, wc);
        checks++;
        if (rd !== 32'hFFFF8ABC) begin errors++; $display("FAIL hload_signed got %h exp ffff8abc", rd); end
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 11'h020, 32'h0, lat, rd, er, wc);
        checks++;
        if (rd !== 32'h00008ABC) begin errors++; $display("FAIL hload_unsigned got %h exp 00008abc", rd); end
    endtask

    task automatic test_errors();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 11'h013, 32'h0, lat, rd, er, wc);
        checks++;
        if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_misalign_word got lat=%0d err=%b rdata=%h exp 1 1 0", lat, er, rd);
        end
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 11'h010, 32'h0, lat, rd, er, wc);
        checks++;
        if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_size11 got lat=%0d err=%b rdata=%h exp 1 1 0", lat, er, rd);
        end
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 11'h011, 32'h0, lat, rd, er, wc);
        checks++;
        if ({lat, er} !== {32'd1, 1'b1}) begin
            errors++; $display("FAIL err_misalign_half got lat=%0d err=%b exp 1 1", lat, er);
        end
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 11'h013, 32'hAAAAAAAA, lat, rd, er, wc);
        checks++;
        if (wc !== 0 || mem[19] !== 8'hEF || er !== 1'b1) begin
            errors++; $display("FAIL err_store_nowrite got we=%0d ram=%h err=%b exp 0 ef 1", wc, mem[19], er);
        end
    endtask

    task automatic test_fetch();
        int lat, wc; logic [31:0] rd; logic er;
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 11'h012, 32'h0, lat, rd, er, wc);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 5) begin
            errors++; $display("FAIL fetch_word got %h lat=%0d exp deadbeef 5", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int stamp[$];
        int exp_order[4] = '{0, 1, 0, 1};
        int both;
        apply_reset();
        both = 0;
        if_addr = 11'h010;
        d_addr = 11'h010; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
            #1;
            if (if_req_ready && d_req_ready) both++;
            if (if_req_ready) begin order.push_back(0); stamp.push_back(cyc); end
            else if (d_req_ready) begin order.push_back(1); stamp.push_back(cyc); end
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (both !== 0) begin errors++; $display("FAIL arb_both_ready got %0d exp 0", both); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= order.size()) begin
                errors++; $display("FAIL arb_grant%0d got none exp %0d", i, exp_order[i]);
            end else if (order[i] !== exp_order[i]) begin
                errors++; $display("FAIL arb_grant%0d got %0d exp %0d", i, order[i], exp_order[i]);
            end else if (i > 0 && (stamp[i] - stamp[i-1]) !== 6) begin
                errors++; $display("FAIL arb_gap%0d got %0d exp 6", i, stamp[i] - stamp[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int wait_c, rsp;
        logic [7:0] old41, old42, old43;
        old41 = mem[65]; old42 = mem[66]; old43 = mem[67];
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_size = 2'b10; d_unsigned = 1'b0;
        d_addr = 11'h040; d_wdata = 32'h11223344;
        #1;
        wait_c = 0;
        while (!d_req_ready && wait_c < 20) begin @(negedge clk); #1; wait_c++; end
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h040) begin
            errors++; $display("FAIL mid_first_byte got we=%b addr=%h exp 1 040", ram_we, ram_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h041 || ram_wdata !== 8'h22) begin
            errors++; $display("FAIL mid_second_byte got we=%b addr=%h wdata=%h exp 1 041 22", ram_we, ram_addr, ram_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 11'h0) begin
            errors++; $display("FAIL mid_reset_drop got we=%b addr=%h exp 0 000", ram_we, ram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (d_rsp_valid || if_rsp_valid || ram_we) rsp++;
            @(negedge clk);
        end
        checks++;
        if (rsp !== 0) begin errors++; $display("FAIL mid_no_activity got %0d exp 0", rsp); end
        checks++;
        if (mem[64] !== 8'h11 || mem[65] !== old41 || mem[66] !== old42 || mem[67] !== old43) begin
            errors++; $display("FAIL mid_ram got %h%h%h%h exp 11 then unchanged", mem[64], mem[65], mem[66], mem[67]);
        end
        if_addr = 11'h000;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        #1;
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_next_grant got %b exp 10", {if_req_ready, d_req_ready});
        end
        @(negedge clk);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        if_req_valid = 1'b0; if_addr = 11'h0;
        d_req_valid = 1'b0; d_addr = 11'h0; d_we = 1'b0; d_size = 2'b00;
        d_unsigned = 1'b0; d_wdata = 32'h0;
        test_reset();
        test_word_store();
        test_word_load();
        test_byte_load();
        test_half();
        test_errors();
        test_fetch();
        test_back_to_back();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
